control_sequencer: RTL and testbench

// Hard-wired control unit that drives the datapath control inputs from IR, replacing the hand-sequenced
// T0..T7 stimulus used for datapath bring-up. Runs fetch (T0-T2), then execute steps for ld, ldi, st,

---
 rtl/control_sequencer_if.sv | 49 ++++
 rtl/control_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control bundle between the hard-wired sequencer and the datapath.
// The sequencer reads IR and mem_ack, and it drives every control strobe.
interface control_sequencer_if;
    logic [31:0] IR;
    logic        mem_ack;
    logic        clear_dp;
    logic        run;
    logic        illegal_op;
    logic [4:0]  op_sel;
    logic        Gra;
    logic        Grb;
    logic        Grc;
    logic        Rin;
    logic        R_out;
    logic        BAout;
    logic        C_out;
    logic        PC_out;
    logic        MDR_out;
    logic        Zlo_out;
    logic        Zhi_out;
    logic        HI_out;
    logic        LO_out;
    logic        In_out;
    logic        MARin;
    logic        MDRin;
    logic        PCin;
    logic        IRin;
    logic        Yin;
    logic        Zlowin;
    logic        IncPC;
    logic        Read;
    logic        Write;

    modport master (
        input  IR, mem_ack,
        output clear_dp, run, illegal_op, op_sel,
        output Gra, Grb, Grc, Rin, R_out, BAout, C_out,
        output PC_out, MDR_out, Zlo_out, Zhi_out, HI_out, LO_out, In_out,
        output MARin, MDRin, PCin, IRin, Yin, Zlowin, IncPC, Read, Write
    );

    modport slave (
        output IR, mem_ack,
        input  clear_dp, run, illegal_op, op_sel,
        input  Gra, Grb, Grc, Rin, R_out, BAout, C_out,
        input  PC_out, MDR_out, Zlo_out, Zhi_out, HI_out, LO_out, In_out,
        input  MARin, MDRin, PCin, IRin, Yin, Zlowin, IncPC, Read, Write
    );
endinterface

// File: rtl/control_sequencer.sv
// Hard-wired Moore control unit: fetch T0-T2, decode in T3, execute T4-T7.
// Memory steps T1, T6 (ld) and T7 (st) hold until mem_ack is seen.
module control_sequencer #(
    parameter logic [4:0] OP_LD   = 5'b00000,
    parameter logic [4:0] OP_LDI  = 5'b00001,
    parameter logic [4:0] OP_ST   = 5'b00010,
    parameter logic [4:0] OP_ADD  = 5'b00011,
    parameter logic [4:0] OP_SUB  = 5'b00100,
    parameter logic [4:0] OP_AND  = 5'b00101,
    parameter logic [4:0] OP_OR   = 5'b00110,
    parameter logic [4:0] OP_ADDI = 5'b01100,
    parameter logic [4:0] OP_NOP  = 5'b11010,
    parameter logic [4:0] OP_HALT = 5'b11011
) (
    input  logic                 clk,
    input  logic                 clr,
    control_sequencer_if.master  bus
);
    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3,
        S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t     state;
    state_t     next;
    logic [4:0] opcode;
    logic       is_ld;
    logic       is_ldi;
    logic       is_st;
    logic       is_addi;
    logic       is_alu;
    logic       is_nop;
    logic       is_halt;
    logic       unused_ir;

    assign opcode    = bus.IR[31:27];
    assign unused_ir = ^bus.IR[26:0];

    assign is_ld   = (opcode == OP_LD);
    assign is_ldi  = (opcode == OP_LDI);
    assign is_st   = (opcode == OP_ST);
    assign is_addi = (opcode == OP_ADDI);
    assign is_nop  = (opcode == OP_NOP);
    assign is_halt = (opcode == OP_HALT);
    assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                     (opcode == OP_AND) || (opcode == OP_OR);

    assign bus.Zhi_out = 1'b0;
    assign bus.HI_out  = 1'b0;
    assign bus.LO_out  = 1'b0;
    assign bus.In_out  = 1'b0;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= S_RESET;
        else      state <= next;
    end

    always_comb begin
        next           = state;
        bus.clear_dp   = 1'b0;
        bus.run        = (state != S_RESET) && (state != S_HALT);
        bus.illegal_op = 1'b0;
        bus.op_sel     = 5'b00000;
        bus.Gra        = 1'b0;
        bus.Grb        = 1'b0;
        bus.Grc        = 1'b0;
        bus.Rin        = 1'b0;
        bus.R_out      = 1'b0;
        bus.BAout      = 1'b0;
        bus.C_out      = 1'b0;
        bus.PC_out     = 1'b0;
        bus.MDR_out    = 1'b0;
        bus.Zlo_out    = 1'b0;
        bus.MARin      = 1'b0;
        bus.MDRin      = 1'b0;
        bus.PCin       = 1'b0;
        bus.IRin       = 1'b0;
        bus.Yin        = 1'b0;
        bus.Zlowin     = 1'b0;
        bus.IncPC      = 1'b0;
        bus.Read       = 1'b0;
        bus.Write      = 1'b0;
        unique case (state)
            S_RESET: begin
                bus.clear_dp = 1'b1;
                next         = S_T0;
            end
            S_T0: begin
                bus.PC_out = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zlowin = 1'b1;
                next       = S_T1;
            end
            // PC reload repeats harmlessly while the fetch read is pending
            S_T1: begin
                bus.Zlo_out = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                if (bus.mem_ack) next = S_T2;
            end
            S_T2: begin
                bus.MDR_out = 1'b1;
                bus.IRin    = 1'b1;
                next        = S_T3;
            end
            S_T3: begin
                unique case (1'b1)
                    is_ld, is_ldi, is_st: begin
                        bus.Grb   = 1'b1;
                        bus.BAout = 1'b1;
                        bus.R_out = 1'b1;
                        bus.Yin   = 1'b1;
                        next      = S_T4;
                    end
                    is_addi, is_alu: begin
                        bus.Grb   = 1'b1;
                        bus.R_out = 1'b1;
                        bus.Yin   = 1'b1;
                        next      = S_T4;
                    end
                    is_nop:  next = S_T0;
                    is_halt: next = S_HALT;
                    default: begin
                        bus.illegal_op = 1'b1;
                        next           = S_T0;
                    end
                endcase
            end
            S_T4: begin
                bus.Zlowin = 1'b1;
                if (is_alu) begin
                    bus.Grc    = 1'b1;
                    bus.R_out  = 1'b1;
                    bus.op_sel = opcode;
                end else begin
                    bus.C_out  = 1'b1;
                    bus.op_sel = OP_ADD;
                end
                next = S_T5;
            end
            S_T5: begin
                bus.Zlo_out = 1'b1;
                if (is_ld || is_st) begin
                    bus.MARin = 1'b1;
                    next      = S_T6;
                end else begin
                    bus.Gra = 1'b1;
                    bus.Rin = 1'b1;
                    next    = S_T0;
                end
            end
            S_T6: begin
                bus.MDRin = 1'b1;
                if (is_st) begin
                    bus.Gra   = 1'b1;
                    bus.R_out = 1'b1;
                    next      = S_T7;
                end else begin
                    bus.Read = 1'b1;
                    if (bus.mem_ack) next = S_T7;
                end
            end
            S_T7: begin
                if (is_st) begin
                    bus.Write = 1'b1;
                    if (bus.mem_ack) next = S_T0;
                end else begin
                    bus.MDR_out = 1'b1;
                    bus.Gra     = 1'b1;
                    bus.Rin     = 1'b1;
                    next        = S_T0;
                end
            end
            S_HALT:  next = S_HALT;
            default: next = S_RESET;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: an instruction-level step table feeds a
// per-cycle expected control word queue that a negedge monitor drains.
module tb_control_sequencer;
    typedef logic [30:0] cw_t;
    typedef struct {
        cw_t w;
        bit  mem;
    } step_t;

    localparam cw_t WR   = 31'(1) << 0;
    localparam cw_t RD   = 31'(1) << 1;
    localparam cw_t INC  = 31'(1) << 2;
    localparam cw_t ZLW  = 31'(1) << 3;
    localparam cw_t YIN  = 31'(1) << 4;
    localparam cw_t IRIN = 31'(1) << 5;
    localparam cw_t PCIN = 31'(1) << 6;
    localparam cw_t MDRI = 31'(1) << 7;
    localparam cw_t MARI = 31'(1) << 8;
    localparam cw_t ZLO  = 31'(1) << 13;
    localparam cw_t MDRO = 31'(1) << 14;
    localparam cw_t PCO  = 31'(1) << 15;
    localparam cw_t CO   = 31'(1) << 16;
    localparam cw_t BA   = 31'(1) << 17;
    localparam cw_t RO   = 31'(1) << 18;
    localparam cw_t RIN  = 31'(1) << 19;
    localparam cw_t GRC  = 31'(1) << 20;
    localparam cw_t GRB  = 31'(1) << 21;
    localparam cw_t GRA  = 31'(1) << 22;
    localparam cw_t ILL  = 31'(1) << 28;
    localparam cw_t RUN  = 31'(1) << 29;
    localparam cw_t CLRD = 31'(1) << 30;

    logic clk;
    logic clr;
    cw_t  act;
    cw_t  exp_q[$];
    step_t plan[$];
    logic [31:0] cur_ir;
    int vectors;
    int errors;
    int cyc;

    control_sequencer_if bus();

    control_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    assign act = {bus.clear_dp, bus.run, bus.illegal_op, bus.op_sel,
                  bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.R_out,
                  bus.BAout, bus.C_out, bus.PC_out, bus.MDR_out,
                  bus.Zlo_out, bus.Zhi_out, bus.HI_out, bus.LO_out,
                  bus.In_out, bus.MARin, bus.MDRin, bus.PCin, bus.IRin,
                  bus.Yin, bus.Zlowin, bus.IncPC, bus.Read, bus.Write};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic cw_t opf(input logic [4:0] o);
        return cw_t'(o) << 23;
    endfunction

    function automatic step_t mk(input cw_t w, input bit mem);
        step_t s;
        s.w   = w | RUN;
        s.mem = mem;
        return s;
    endfunction

    // Instruction-level view: the sequence of control steps for one opcode
    task automatic make_plan(input logic [31:0] ir);
        logic [4:0] op;
        op = ir[31:27];
        plan.delete();
        plan.push_back(mk(PCO | MARI | INC | ZLW, 0));
        plan.push_back(mk(ZLO | PCIN | RD | MDRI, 1));
        plan.push_back(mk(MDRO | IRIN, 0));
        case (op)
            5'b00000: begin
                plan.push_back(mk(GRB | BA | RO | YIN, 0));
                plan.push_back(mk(CO | ZLW | opf(5'b00011), 0));
                plan.push_back(mk(ZLO | MARI, 0));
                plan.push_back(mk(RD | MDRI, 1));
                plan.push_back(mk(MDRO | GRA | RIN, 0));
            end
            5'b00001: begin
                plan.push_back(mk(GRB | BA | RO | YIN, 0));
                plan.push_back(mk(CO | ZLW | opf(5'b00011), 0));
                plan.push_back(mk(ZLO | GRA | RIN, 0));
            end
            5'b00010: begin
                plan.push_back(mk(GRB | BA | RO | YIN, 0));
                plan.push_back(mk(CO | ZLW | opf(5'b00011), 0));
                plan.push_back(mk(ZLO | MARI, 0));
                plan.push_back(mk(GRA | RO | MDRI, 0));
                plan.push_back(mk(WR, 1));
            end
            5'b01100: begin
                plan.push_back(mk(GRB | RO | YIN, 0));
                plan.push_back(mk(CO | ZLW | opf(5'b00011), 0));
                plan.push_back(mk(ZLO | GRA | RIN, 0));
            end
            5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
                plan.push_back(mk(GRB | RO | YIN, 0));
                plan.push_back(mk(GRC | RO | ZLW | opf(op), 0));
                plan.push_back(mk(ZLO | GRA | RIN, 0));
            end
            5'b11010, 5'b11011: plan.push_back(mk('0, 0));
            default: plan.push_back(mk(ILL, 0));
        endcase
    endtask

    task automatic tick(input cw_t w, input logic ack, input logic rst_n);
        @(posedge clk);
        #1;
        clr         = rst_n;
        bus.IR      = cur_ir;
        bus.mem_ack = ack;
        exp_q.push_back(w);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) tick(CLRD, 1'($urandom), 1'b0);
        tick(CLRD, 1'($urandom), 1'b1);
    endtask

    // abort_at: cycle index inside the instruction at which clr drops
    task automatic exec(input logic [31:0] ir, input int wf,
                        input int wx, input int abort_at);
        int c;
        int n;
        c = 0;
        cur_ir = ir;
        make_plan(ir);
        for (int i = 0; i < plan.size(); i++) begin
            n = plan[i].mem ? ((i == 1) ? wf : wx) : 0;
            for (int k = 0; k <= n; k++) begin
                if (c == abort_at) begin
                    do_reset(1 + int'($urandom_range(0, 2)));
                    return;
                end
                if (plan[i].mem) tick(plan[i].w, k == n, 1'b1);
                else             tick(plan[i].w, 1'($urandom), 1'b1);
                c++;
            end
        end
        if (ir[31:27] == 5'b11011) begin
            for (int i = 0; i < 20; i++) tick('0, 1'($urandom), 1'b1);
            do_reset(2);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                cw_t e;
                e = exp_q.pop_front();
                vectors++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL ctrl cyc=%0d got=%h exp=%h", cyc, act, e);
                end
                vectors++;
                if ((bus.Read && bus.Write) || (bus.Rin && bus.Write)) begin
                    errors++;
                    $display("FAIL excl cyc=%0d got=%h exp=no_overlap", cyc, act);
                end
            end
            cyc++;
        end
    end

    initial begin
        logic [31:0] ir;
        logic [4:0]  ops[10];
        int          sel;
        int          ab;
        vectors     = 0;
        errors      = 0;
        cyc         = 0;
        cur_ir      = 32'h0;
        clr         = 1'b0;
        bus.IR      = 32'h0;
        bus.mem_ack = 1'b0;
        ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
                5'b00101, 5'b00110, 5'b01100, 5'b11010, 5'b11011};
        do_reset(2);
        exec(32'h11800034, 0, 0, -1);
        exec(32'h11800034, 3, 0, -1);
        exec(32'h18918000, 0, 0, -1);
        exec(32'h00880010, 0, 2, -1);
        exec(32'h0A000005, 1, 0, -1);
        exec(32'h61100007, 0, 0, -1);
        exec(32'hD0000000, 0, 0, -1);
        exec(32'h38000000, 0, 0, -1);
        exec(32'h11800034, 0, 0, 6);
        exec(32'h21918000, 2, 0, -1);
        exec(32'hD8000000, 0, 0, -1);
        for (int t = 0; t < 300; t++) begin
            sel = int'($urandom_range(0, 11));
            ir  = $urandom;
            if (sel < 10) ir[31:27] = ops[sel];
            if (ir[31:27] == 5'b11011 && $urandom_range(0, 3) != 0)
                ir[31:27] = 5'b11010;
            ab = ($urandom_range(0, 19) == 0) ?
                 int'($urandom_range(0, 9)) : -1;
            exec(ir, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), ab);
        end
        @(negedge clk);
        repeat (2) @(posedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
